// File: rtl/led_blink_scheduler.sv
// Four-channel LED sequencer: one shared base-tick prescaler and an IDLE/BLINK/CHASE/ALL_ON mode FSM.
// Outputs registered, mode and entry LEDs update on the pulse edge; no backpressure, every pulse honoured.
module led_blink_scheduler #(
  parameter int CLKS_PER_TICK = 250000,
  parameter int HALF_1        = 5,
  parameter int HALF_2        = 10,
  parameter int HALF_3        = 25,
  parameter int HALF_4        = 50,
  parameter int CHASE_TICKS   = 25
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Mode_Pulse,
  output logic [1:0] o_Mode,
  output logic       o_Tick,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4
);

  localparam int            PW         = $clog2(CLKS_PER_TICK);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_TICK - 1);
  localparam logic [7:0]    CHASE_LAST = 8'(CHASE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLINK  = 2'd1,
    CHASE  = 2'd2,
    ALL_ON = 2'd3
  } mode_t;

  mode_t         mode_q, mode_d;
  logic [PW-1:0] presc_q;
  logic          tick;
  logic [7:0]    ch_cnt_q [4];
  logic [7:0]    half_last [4];
  logic [7:0]    dwell_q;
  logic [1:0]    chase_idx_q;
  logic [3:0]    led_q;

  assign half_last[0] = 8'(HALF_1 - 1);
  assign half_last[1] = 8'(HALF_2 - 1);
  assign half_last[2] = 8'(HALF_3 - 1);
  assign half_last[3] = 8'(HALF_4 - 1);

  assign tick = (presc_q == PRESC_LAST);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) mode_q <= IDLE;
    else          mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (i_Mode_Pulse) begin
      case (mode_q)
        IDLE:   mode_d = BLINK;
        BLINK:  mode_d = CHASE;
        CHASE:  mode_d = ALL_ON;
        ALL_ON: mode_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      presc_q     <= '0;
      o_Tick      <= 1'b0;
      dwell_q     <= '0;
      chase_idx_q <= '0;
      led_q       <= '0;
      for (int k = 0; k < 4; k++) ch_cnt_q[k] <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      o_Tick  <= tick;
      if (i_Mode_Pulse) begin
        // A tick landing on the pulse edge is dropped so every mode starts from a full period.
        for (int k = 0; k < 4; k++) ch_cnt_q[k] <= '0;
        dwell_q     <= '0;
        chase_idx_q <= '0;
        case (mode_d)
          IDLE:   led_q <= 4'b0000;
          BLINK:  led_q <= 4'b0000;
          CHASE:  led_q <= 4'b0001;
          ALL_ON: led_q <= 4'b1111;
        endcase
      end else if (tick) begin
        case (mode_q)
          BLINK: begin
            for (int k = 0; k < 4; k++) begin
              if (ch_cnt_q[k] == half_last[k]) begin
                ch_cnt_q[k] <= '0;
                led_q[k]    <= ~led_q[k];
              end else begin
                ch_cnt_q[k] <= ch_cnt_q[k] + 8'd1;
              end
            end
          end
          CHASE: begin
            if (dwell_q == CHASE_LAST) begin
              dwell_q     <= '0;
              chase_idx_q <= chase_idx_q + 2'd1;
              led_q       <= 4'b0001 << (chase_idx_q + 2'd1);
            end else begin
              dwell_q <= dwell_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_Mode  = mode_q;
  assign o_LED_1 = led_q[0];
  assign o_LED_2 = led_q[1];
  assign o_LED_3 = led_q[2];
  assign o_LED_4 = led_q[3];

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Self-checking bench for led_blink_scheduler: per-cycle scoreboard against a tick-count model,
// plus directed checks on reset timing, blink rates, chase rotation, mode sequence and coincident events.
module tb_led_blink_scheduler;

  localparam int CPT      = 4;
  localparam int CT       = 3;
  localparam int HALF [4] = '{1, 2, 5, 10};

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic       i_Mode_Pulse;
  logic [1:0] o_Mode;
  logic       o_Tick;
  logic       o_LED_1, o_LED_2, o_LED_3, o_LED_4;
  logic [3:0] leds;

  assign leds = {o_LED_4, o_LED_3, o_LED_2, o_LED_1};

  typedef struct packed {
    logic [1:0] mode;
    logic       tick;
    logic [3:0] leds;
  } exp_t;

  exp_t       exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;
  int         m_cyc = 0;
  int         m_ticks = 0;
  logic [1:0] m_mode = 2'd0;

  always #5 i_Clk = ~i_Clk;

  led_blink_scheduler #(
    .CLKS_PER_TICK(CPT),
    .HALF_1(1),
    .HALF_2(2),
    .HALF_3(5),
    .HALF_4(10),
    .CHASE_TICKS(CT)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_Mode_Pulse(i_Mode_Pulse),
    .o_Mode(o_Mode),
    .o_Tick(o_Tick),
    .o_LED_1(o_LED_1),
    .o_LED_2(o_LED_2),
    .o_LED_3(o_LED_3),
    .o_LED_4(o_LED_4)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // LED pattern as a function of ticks counted since mode entry.
  function automatic logic [3:0] model_leds(input logic [1:0] mode, input int ticks);
    logic [3:0] r;
    r = 4'h0;
    case (mode)
      2'd1: for (int k = 0; k < 4; k++) r[k] = ((ticks / HALF[k]) % 2) == 1;
      2'd2: r[(ticks / CT) % 4] = 1'b1;
      2'd3: r = 4'hF;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  task automatic step(input logic rst, input logic pulse);
    exp_t e;
    exp_t want;
    i_Rst_L      = rst;
    i_Mode_Pulse = pulse;
    if (!rst) begin
      m_cyc   = 0;
      m_ticks = 0;
      m_mode  = 2'd0;
      e.tick  = 1'b0;
    end else begin
      m_cyc++;
      e.tick = (m_cyc % CPT) == 0;
      if (pulse) begin
        m_mode  = m_mode + 2'd1;
        m_ticks = 0;
      end else if (e.tick) begin
        m_ticks++;
      end
    end
    e.mode = m_mode;
    e.leds = model_leds(m_mode, m_ticks);
    exp_q.push_back(e);
    @(posedge i_Clk);
    #1;
    want = exp_q.pop_front();
    chk_eq("mode", 32'(o_Mode), 32'(want.mode));
    chk_eq("tick", 32'(o_Tick), 32'(want.tick));
    chk_eq("leds", 32'(leds), 32'(want.leds));
  endtask

  initial begin
    int         first_tick;
    int         n_ticks;
    int         steps;
    int         n_moves;
    int         tog [4];
    int         mode_seq [4];
    int         led_seq [4];
    logic [3:0] prev;
    logic       aligned;
    logic       onehot;

    mode_seq = '{1, 2, 3, 0};
    led_seq  = '{0, 1, 15, 0};
    i_Rst_L      = 1'b0;
    i_Mode_Pulse = 1'b0;

    repeat (3) step(1'b0, 1'b0);
    chk_eq("rst_mode", 32'(o_Mode), 32'd0);
    chk_eq("rst_leds", 32'(leds), 32'd0);
    first_tick = -1;
    n_ticks    = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0);
      if (o_Tick) begin
        n_ticks++;
        if (first_tick < 0) first_tick = i;
      end
    end
    chk_eq("first_tick_cycle", 32'(first_tick), 32'(CPT));
    chk_eq("ticks_in_12", 32'(n_ticks), 32'd3);

    step(1'b1, 1'b1);
    chk_eq("blink_entry_mode", 32'(o_Mode), 32'd1);
    chk_eq("blink_entry_leds", 32'(leds), 32'd0);
    tog     = '{0, 0, 0, 0};
    aligned = 1'b1;
    prev    = leds;
    repeat (80) begin
      step(1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
        if (leds[k] != prev[k]) begin
          tog[k]++;
          if (!o_Tick) aligned = 1'b0;
        end
      end
      prev = leds;
    end
    for (int k = 0; k < 4; k++)
      chk_eq($sformatf("blink_toggles_led%0d", k + 1), 32'(tog[k]), 32'(80 / CPT / HALF[k]));
    chk_eq("blink_tick_aligned", 32'(aligned), 32'd1);

    step(1'b1, 1'b1);
    chk_eq("chase_entry_leds", 32'(leds), 32'd1);
    onehot  = 1'b1;
    n_moves = 0;
    prev    = leds;
    repeat (12 * CPT) begin
      step(1'b1, 1'b0);
      if ($countones(leds) != 1) onehot = 1'b0;
      if (leds != prev) n_moves++;
      prev = leds;
    end
    chk_eq("chase_onehot", 32'(onehot), 32'd1);
    chk_eq("chase_moves_12_ticks", 32'(n_moves), 32'd4);
    chk_eq("chase_wrap_led1", 32'(leds), 32'd1);

    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk_eq("back_to_idle", 32'(o_Mode), 32'd0);
    for (int p = 0; p < 4; p++) begin
      step(1'b1, 1'b1);
      chk_eq($sformatf("cycle_mode_%0d", p), 32'(o_Mode), 32'(mode_seq[p]));
      chk_eq($sformatf("cycle_leds_%0d", p), 32'(leds), 32'(led_seq[p]));
      repeat (9) step(1'b1, 1'b0);
    end

    step(1'b1, 1'b1);
    steps = 0;
    while (!o_Tick && steps < 20) begin
      step(1'b1, 1'b0);
      steps++;
    end
    chk_eq("tick_wait", 32'(o_Tick), 32'd1);
    repeat (CPT - 1) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk_eq("coinc_tick", 32'(o_Tick), 32'd1);
    chk_eq("coinc_mode", 32'(o_Mode), 32'd2);
    chk_eq("coinc_leds", 32'(leds), 32'd1);
    steps = 0;
    while (leds == 4'b0001 && steps < 40) begin
      step(1'b1, 1'b0);
      steps++;
    end
    chk_eq("coinc_first_step_cycles", 32'(steps), 32'(CT * CPT));
    chk_eq("coinc_step_led2", 32'(leds), 32'd2);
    step(1'b1, 1'b1);
    chk_eq("coinc_next_mode", 32'(o_Mode), 32'd3);
    repeat (5) step(1'b1, 1'b0);

    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    steps = 0;
    while (leds != 4'b0100 && steps < 60) begin
      step(1'b1, 1'b0);
      steps++;
    end
    chk_eq("chase_led3_reached", 32'(leds), 32'd4);
    step(1'b0, 1'b1);
    chk_eq("midrst_mode", 32'(o_Mode), 32'd0);
    chk_eq("midrst_leds", 32'(leds), 32'd0);
    repeat (2) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk_eq("post_rst_blink_mode", 32'(o_Mode), 32'd1);
    chk_eq("post_rst_blink_leds", 32'(leds), 32'd0);
    repeat (10) step(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_blink_scheduler.md
# led_blink_scheduler

Four-channel LED sequencer for the board's LED bank. A single shared prescaler generates a base tick, and a mode state machine decides what drives the LEDs: all off, independent blink at four fixed rates, a rotating chase, or all on. Modes advance on a one-cycle strobe from the existing switch debouncer. The block sits between that debouncer and the four LED pins and replaces the free-running per-LED blink counters.

## Interface
- CLKS_PER_TICK, 250000, clock cycles per base tick (100 Hz at 25 MHz); must be ≥2
- HALF_1, 5, LED 1 half-period in ticks (10 Hz blink); 1..255
- HALF_2, 10, LED 2 half-period in ticks (5 Hz); 1..255
- HALF_3, 25, LED 3 half-period in ticks (2 Hz); 1..255
- HALF_4, 50, LED 4 half-period in ticks (1 Hz); 1..255
- CHASE_TICKS, 25, ticks each LED stays lit in CHASE; 1..255

- i_Clk  in  1  system clock; the only clock
- i_Rst_L  in  1  synchronous, active-low reset
- i_Mode_Pulse  in  1  one-cycle strobe that advances the mode
- o_Mode  out  2  current mode: 0=IDLE, 1=BLINK, 2=CHASE, 3=ALL_ON
- o_Tick  out  1  one-cycle base-tick strobe, for observation
- o_LED_1..o_LED_4  out  1 each  LED drives, active high

## Operation
- **Reset:** i_Rst_L=0 sampled at an edge gives the following values after that edge.
  - o_Mode=0 (IDLE).
  - All LEDs 0, o_Tick=0.
  - Prescaler, channel counters and chase index all 0.
  - i_Mode_Pulse is ignored while reset is asserted.
- **Prescaler:** free-running counter over 0..CLKS_PER_TICK-1.
  - o_Tick=1 for exactly the one cycle in which the counter equals CLKS_PER_TICK-1; the counter wraps to 0 on that edge.
  - The prescaler is never cleared by a mode change, only by reset.
- **Mode FSM:** IDLE → BLINK → CHASE → ALL_ON → IDLE, one step per i_Mode_Pulse.
  - Any transition clears all four channel counters and the chase index.
  - IDLE: all LEDs 0.
  - BLINK: LED k toggles when a tick occurs and its counter equals HALF_k-1; the counter then returns to 0. Otherwise each tick increments the counter. Channel counters are 8 bits and never exceed HALF_k-1.
  - CHASE: exactly one LED is lit, chosen by the 2-bit index (0 → LED_1 … 3 → LED_4). A single 8-bit dwell counter advances on ticks. When it reaches CHASE_TICKS-1 and a tick occurs, the index increments (wrapping 3 → 0) and the dwell counter clears.
  - ALL_ON: all LEDs 1.
- **Entry values:** set on the same edge that samples the pulse.
  - BLINK entry: all LEDs 0.
  - CHASE entry: LED_1=1, others 0.
  - ALL_ON entry: all 1.
  - IDLE entry: all 0.
- **Simultaneous pulse and tick:** the mode change wins and that tick does not advance any channel or chase counter. o_Tick still pulses.
- **Back-to-back pulses:** every pulse is honoured, including on consecutive cycles; there is no lockout.

## Timing
- All outputs are registered.
- o_Mode and the entry LED values change on the first edge at which i_Mode_Pulse=1 is sampled (zero-cycle registered latency).
- LED toggles and chase steps appear on the edge that samples o_Tick's source condition. An LED changes in the same cycle o_Tick is high, as seen after that edge.
- First BLINK toggle of LED k: on the HALF_k-th tick after entry. Subsequent toggles occur every HALF_k×CLKS_PER_TICK cycles exactly.
- A tick coincident with the entry pulse is not counted (see simultaneous-event rule).
- Reset asserted mid-mode takes effect on that edge. Deasserting it resumes in IDLE with the prescaler starting from 0, so the first tick comes CLKS_PER_TICK cycles after the first edge sampling i_Rst_L=1.

## Test plan
Bench parameters: CLKS_PER_TICK=4, HALF_1..4=1,2,5,10, CHASE_TICKS=3.

- **Reset:** hold i_Rst_L=0 for 3 cycles, then release. → o_Mode=0, all LEDs 0. o_Tick first high exactly 4 cycles after release, then every 4 cycles.
- **BLINK rates:** enter BLINK and run 80 cycles (20 ticks). → LED_1 toggles every tick (20 toggles), LED_2 every 2 ticks (10), LED_3 every 5 (4), LED_4 every 10 (2). All toggles are aligned to o_Tick.
- **CHASE rotation:** enter CHASE. → LED_1 lit immediately. After 3 ticks LED_2 only, after 6 LED_3, after 9 LED_4, after 12 LED_1 again. Exactly one LED is high at every cycle.
- **Full mode cycle:** issue 4 pulses 10 cycles apart. → o_Mode sequence 1, 2, 3, 0. ALL_ON shows LEDs 1111; IDLE shows LEDs 0000.
- **Pulse coincident with tick:** in BLINK, pulse on an o_Tick cycle (→ CHASE), then pulse again. → Counters restart; the first chase step comes 3 full ticks after entry, not 2.
- **Reset mid-mode:** assert reset for 1 cycle during CHASE with LED_3 lit. → All LEDs 0 and o_Mode=0 on that edge. A subsequent pulse enters BLINK with all LEDs 0.
